// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
// Package  : float_pkg
// Brief    : Shared FSM encoding, default format widths and special-value
//            constant builders for the constant-subtract float unit.
// Revision : 1.0
// ============================================================================
package float_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN  = 3'd1,
    S_ADDSUB = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Results are right-aligned in 64 bits; callers size-cast to their width.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] inf_bits(input logic sign, input int exp_w, input int man_w);
    return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_sub_const_lzc.sv
`default_nettype none
// ============================================================================
// Module   : lzc
// Brief    : Combinational leading-zero counter; all-zero input gives WIDTH.
// Revision : 1.0
// ============================================================================
module lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_cnt
);

  // Later (higher) set bits override earlier ones, leaving the MSB-most one.
  always_comb begin
    o_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) begin
        o_cnt = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_sub_const.sv
`default_nettype none
// ============================================================================
// Module   : float_sub_const
// Brief    : Five-step sequential float subtract against a fixed constant,
//            CONST - float_in (op=0) or float_in - CONST (op=1), RNE rounding.
// Revision : 1.0
// ============================================================================
module float_sub_const
  import float_pkg::*;
#(
  parameter int                   EXP_W = DEF_EXP_W,
  parameter int                   MAN_W = DEF_MAN_W,
  parameter logic [EXP_W+MAN_W:0] CONST = 32'h3FC00000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   float_in,
  output logic [EXP_W+MAN_W:0]   float_out,
  output logic                   ready
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int EXT   = MAN_W + 4;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = $clog2(EXT + 1);

  localparam logic [W-1:0]         c_QNAN      = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic [W-1:0]         c_INF_POS   = W'(inf_bits(1'b0, EXP_W, MAN_W));
  localparam logic [W-1:0]         c_INF_NEG   = W'(inf_bits(1'b1, EXP_W, MAN_W));
  localparam logic [EXP_W-1:0]     c_SHIFT_LIM = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0] c_EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] c_EXP_INF   = EW'((2 ** EXP_W) - 1);

  if ((CONST[W-2 -: EXP_W] == {EXP_W{1'b1}}) && (CONST[MAN_W-1:0] == '0)) begin : g_const_inf_err
    $error("float_sub_const: CONST must not be an infinity");
  end

  state_t                 r_state;
  logic                   r_op;
  logic [W-1:0]           r_in;
  logic                   r_sign;
  logic                   r_sub;
  logic signed [EW-1:0]   r_exp;
  logic [EXT-1:0]         r_big;
  logic [EXT-1:0]         r_sml;
  logic [EXT:0]           r_sum;
  logic [EXT-1:0]         r_norm;
  logic                   r_zero;
  logic                   r_spec;
  logic [W-1:0]           r_spec_val;
  logic [W-1:0]           r_out;
  logic                   r_ready;

  // ---------------- ALIGN: minuend a plus negated subtrahend b -------------
  logic [W-1:0]     w_a, w_b;
  logic             w_a_sign, w_b_sign;
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W:0]   w_a_sig, w_b_sig;
  logic             w_swap;
  logic             w_big_sign, w_sml_sign;
  logic [EXP_W-1:0] w_big_exp, w_sml_exp, w_diff;
  logic [MAN_W:0]   w_big_sig, w_sml_sig;
  logic [EXT-1:0]   w_sml_ext, w_lost_mask, w_sml_al;

  assign w_a      = r_op ? r_in : CONST;
  assign w_b      = r_op ? CONST : r_in;
  assign w_a_sign = w_a[W-1];
  assign w_b_sign = ~w_b[W-1];
  assign w_a_exp  = w_a[W-2 -: EXP_W];
  assign w_b_exp  = w_b[W-2 -: EXP_W];
  // Denormals collapse to a zero significand with exponent 0.
  assign w_a_sig  = (w_a_exp == '0) ? '0 : {1'b1, w_a[MAN_W-1:0]};
  assign w_b_sig  = (w_b_exp == '0) ? '0 : {1'b1, w_b[MAN_W-1:0]};
  assign w_swap   = {w_b_exp, w_b_sig} > {w_a_exp, w_a_sig};

  assign w_big_sign = w_swap ? w_b_sign : w_a_sign;
  assign w_sml_sign = w_swap ? w_a_sign : w_b_sign;
  assign w_big_exp  = w_swap ? w_b_exp  : w_a_exp;
  assign w_sml_exp  = w_swap ? w_a_exp  : w_b_exp;
  assign w_big_sig  = w_swap ? w_b_sig  : w_a_sig;
  assign w_sml_sig  = w_swap ? w_a_sig  : w_b_sig;
  assign w_diff     = w_big_exp - w_sml_exp;

  assign w_sml_ext   = {w_sml_sig, 3'b000};
  assign w_lost_mask = ~({EXT{1'b1}} << w_diff);
  assign w_sml_al    = (w_diff >= c_SHIFT_LIM)
                     ? {{(EXT-1){1'b0}}, |w_sml_ext}
                     : ((w_sml_ext >> w_diff) | {{(EXT-1){1'b0}}, |(w_sml_ext & w_lost_mask)});

  logic [EXP_W-1:0] w_in_exp;
  logic             w_in_nan, w_in_inf, w_k_nan;
  logic [W-1:0]     w_in_inf_val;

  assign w_in_exp     = r_in[W-2 -: EXP_W];
  assign w_in_nan     = (&w_in_exp) & (|r_in[MAN_W-1:0]);
  assign w_in_inf     = (&w_in_exp) & ~(|r_in[MAN_W-1:0]);
  assign w_k_nan      = (&CONST[W-2 -: EXP_W]) & (|CONST[MAN_W-1:0]);
  assign w_in_inf_val = (r_in[W-1] ^ ~r_op) ? c_INF_NEG : c_INF_POS;

  // ---------------- NORM / ROUND datapath ---------------------------------
  logic [CNT_W-1:0]     w_lz;
  logic signed [EW-1:0] w_lz_ext;

  lzc #(
    .WIDTH (EXT),
    .CNT_W (CNT_W)
  ) u_lzc (
    .i_data (r_sum[EXT-1:0]),
    .o_cnt  (w_lz)
  );

  assign w_lz_ext = $signed({{(EW-CNT_W){1'b0}}, w_lz});

  logic                 w_up;
  logic [MAN_W+1:0]     w_rsig;
  logic signed [EW-1:0] w_rexp;
  logic [W-1:0]         w_result;

  // Round-to-nearest-even on guard (bit 2) with round|sticky below it.
  assign w_up   = r_norm[2] & (r_norm[3] | r_norm[1] | r_norm[0]);
  assign w_rsig = {1'b0, r_norm[EXT-1:3]} + {{(MAN_W+1){1'b0}}, w_up};
  assign w_rexp = r_exp + $signed({{(EW-1){1'b0}}, w_rsig[MAN_W+1]});

  always_comb begin
    w_result = {r_sign, w_rexp[EXP_W-1:0], w_rsig[MAN_W-1:0]};
    if (r_spec) begin
      w_result = r_spec_val;
    end else if (r_zero || (w_rexp < c_EXP_ONE)) begin
      w_result = '0;
    end else if (w_rexp >= c_EXP_INF) begin
      w_result = r_sign ? c_INF_NEG : c_INF_POS;
    end
  end

  // ---------------- Control ----------------------------------------------
  logic w_accept;
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_in       <= '0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_exp      <= '0;
      r_big      <= '0;
      r_sml      <= '0;
      r_sum      <= '0;
      r_norm     <= '0;
      r_zero     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_val <= '0;
      r_out      <= '0;
      r_ready    <= 1'b0;
    end else begin
      // ready trails DONE by one edge, and drops on the accepting edge.
      r_ready <= (r_state == S_DONE) && !w_accept;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_in    <= float_in;
            r_op    <= op;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign     <= w_big_sign;
          r_sub      <= w_big_sign ^ w_sml_sign;
          r_exp      <= $signed({2'b00, w_big_exp});
          r_big      <= {w_big_sig, 3'b000};
          r_sml      <= w_sml_al;
          r_spec     <= w_in_nan | w_in_inf | w_k_nan;
          r_spec_val <= (w_in_nan | w_k_nan) ? c_QNAN : w_in_inf_val;
          r_state    <= S_ADDSUB;
        end
        S_ADDSUB: begin
          r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_sml})
                           : ({1'b0, r_big} + {1'b0, r_sml});
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_zero <= (r_sum == '0);
          if (r_sum[EXT]) begin
            r_norm <= {r_sum[EXT:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + c_EXP_ONE;
          end else begin
            r_norm <= r_sum[EXT-1:0] << w_lz;
            r_exp  <= r_exp - w_lz_ext;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_out   <= w_result;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign float_out = r_out;
  assign ready     = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_float_sub_const.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_sub_const
// Brief    : Directed and random checks of float_sub_const against an exact
//            integer-arithmetic reference for the default 1.5 constant.
// Revision : 1.0
// ============================================================================
module tb_float_sub_const;

  localparam logic [31:0] K = 32'h3FC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] float_in;
  logic [31:0] float_out;
  logic        ready;

  int n_vec  = 0;
  int n_miss = 0;

  float_sub_const dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .float_in  (float_in),
    .float_out (float_out),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact value of (a - b) as an integer in units of 2^(emin-150), then RNE.
  function automatic logic [31:0] ref_sub(input logic op_i, input logic [31:0] x);
    logic [31:0]         a, b;
    logic signed [319:0] va, vb, v;
    logic [319:0]        m, q, rem, half;
    int                  ea, eb, emin, p, e, sh;
    logic                s;
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 32'h7FC00000;
    if (x[30:23] == 8'hFF) return {x[31] ^ ~op_i, 8'hFF, 23'd0};
    a  = op_i ? x : K;
    b  = op_i ? K : x;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    va = '0;
    vb = '0;
    if (a[30:23] != 8'd0) va[23:0] = {1'b1, a[22:0]};
    if (b[30:23] != 8'd0) vb[23:0] = {1'b1, b[22:0]};
    va = va <<< (ea - emin);
    vb = vb <<< (eb - emin);
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    v = va - vb;
    if (v == '0) return 32'h00000000;
    s = v[319];
    m = s ? -v : v;
    p = 0;
    for (int i = 0; i < 320; i++) if (m[i]) p = i;
    e = p + emin - 23;
    if (p > 23) begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 320'd1;
      if (q[24]) begin
        q = q >> 1;
        e++;
      end
    end else begin
      q = m << (23 - p);
    end
    if (e <= 0) return 32'h00000000;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: r[30:23] = 8'($urandom_range(125, 129));
      1: r[30:23] = 8'($urandom_range(87, 167));
      2: begin
        r[30:23] = 8'd127;
        r[22:0]  = 23'h400000 ^ 23'($urandom_range(0, 15));
      end
      default: r[30:23] = 8'($urandom_range(100, 150));
    endcase
    return r;
  endfunction

  // Start, scramble the inputs, then verify the fixed ready timing and result.
  task automatic run_vec(input logic op_i, input logic [31:0] x, input logic [31:0] exp,
                         input string tag);
    start    = 1'b1;
    op       = op_i;
    float_in = x;
    step();
    start    = 1'b0;
    float_in = $urandom;
    op       = 1'($urandom);
    n_vec++;
    check({tag, "/ready_fall"}, {31'd0, ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check({tag, "/ready_busy"}, {31'd0, ready}, 32'd0);
    end
    step();
    check({tag, "/ready_done"}, {31'd0, ready}, 32'd1);
    check({tag, "/result"}, float_out, exp);
  endtask

  initial begin
    logic        rop;
    logic [31:0] rx;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    float_in = '0;
    step();
    step();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_out", float_out, 32'd0);

    rst = 1'b0;
    run_vec(1'b0, 32'h3F800000, 32'h3F000000, "one");
    run_vec(1'b0, 32'h3FC00000, 32'h00000000, "equal");
    run_vec(1'b1, 32'h40000000, 32'h3F000000, "two_op1");
    run_vec(1'b0, 32'h7FC00001, 32'h7FC00000, "nan");
    run_vec(1'b0, 32'h7F800000, 32'hFF800000, "inf_op0");
    run_vec(1'b1, 32'h7F800000, 32'h7F800000, "inf_op1");
    run_vec(1'b0, 32'h33800000, 32'h3FC00000, "tie_even");
    run_vec(1'b0, 32'h00000001, 32'h3FC00000, "denorm");
    run_vec(1'b1, 32'h80000000, 32'hBFC00000, "neg_zero");
    run_vec(1'b1, 32'h3FC00000, 32'h00000000, "equal_op1");
    run_vec(1'b0, 32'hBFC00000, 32'h40400000, "add_path");

    repeat (6) step();
    check("hold_ready", {31'd0, ready}, 32'd1);
    check("hold_out", float_out, 32'h40400000);

    // start pulses during ALIGN/ADDSUB must not disturb the running op
    start    = 1'b1;
    op       = 1'b0;
    float_in = 32'h40000000;
    step();
    n_vec++;
    check("busy/ready_fall", {31'd0, ready}, 32'd0);
    float_in = 32'h3F800000;
    op       = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    step();
    check("busy/ready_busy", {31'd0, ready}, 32'd0);
    step();
    check("busy/ready_done", {31'd0, ready}, 32'd1);
    check("busy/result", float_out, 32'hBF000000);

    // reset while in NORM aborts with no ready pulse
    start    = 1'b1;
    op       = 1'b0;
    float_in = 32'h3F800000;
    step();
    start = 1'b0;
    step();
    step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    n_vec++;
    check("abort/ready", {31'd0, ready}, 32'd0);
    check("abort/out", float_out, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort/no_pulse", {31'd0, ready}, 32'd0);
    end
    check("abort/out_held", float_out, 32'd0);

    // back-to-back random vectors restarting from DONE
    for (int i = 0; i < 150; i++) begin
      rop = 1'($urandom);
      rx  = rand_operand();
      run_vec(rop, rx, ref_sub(rop, rx), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_sub_const.md
FLOAT_SUB_CONST -- requirements
Module: float_sub_const

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter CONST, default 32'h3FC00000 (1.5), W-bit constant operand in the same format.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request; sampled only in IDLE or DONE.
REQ-007 SHALL have port op, input, 1, mode: 0 = CONST - float_in, 1 = float_in - CONST; captured with start.
REQ-008 SHALL have port float_in, input, W, operand; captured on the start edge.
REQ-009 SHALL have port float_out, output, W, registered result; valid while ready=1.
REQ-010 SHALL have port ready, output, 1, level; high in DONE until the next accepted start.

Function
REQ-011 SHALL implement FSM IDLE -> ALIGN -> ADDSUB -> NORM -> ROUND -> DONE, advancing one state per cycle.
REQ-012 SHALL accept start in IDLE or DONE, capture float_in/op, and enter ALIGN; ready SHALL fall on the cycle after acceptance.
REQ-013 SHALL give fixed latency: start sampled at edge N -> ready=1 and float_out valid after edge N+5.
REQ-014 SHALL ignore start in ALIGN..ROUND; captured operands SHALL NOT change mid-operation.
REQ-015 SHALL hold float_out and ready=1 in DONE indefinitely until start; start in DONE restarts directly, without IDLE.
REQ-016 ALIGN SHALL swap operands so the larger magnitude is first and right-shift the smaller mantissa by the exponent difference; shifted-out bits SHALL fold into sticky; a difference >= MAN_W+3 SHALL leave sticky only.
REQ-017 ADDSUB SHALL add or subtract magnitudes per effective sign (op XOR sign bits) in MAN_W+4 bits: hidden, mantissa, guard, round, sticky, plus carry.
REQ-018 NORM SHALL right-shift 1 on carry, otherwise left-shift by leading-zero count in one cycle, adjusting exponent.
REQ-019 ROUND SHALL apply round-to-nearest-even; mantissa overflow from rounding SHALL increment the exponent.
REQ-020 Exact-zero result SHALL be +0 (all zeros).
REQ-021 Denormal inputs (exp=0) SHALL be treated as zero of the same sign; results below min normal SHALL flush to +0.
REQ-022 Exponent overflow SHALL give infinity with the result sign.
REQ-023 NaN input SHALL give canonical quiet NaN (sign 0, exp all ones, mantissa MSB 1, rest 0).
REQ-024 Infinite float_in SHALL give infinity with sign (sign(float_in) XOR ~op); infinite CONST is a parameter error, flagged by elaboration assertion.

Reset
REQ-025 rst=1 at a rising edge SHALL force state IDLE, ready=0, float_out=0, and clear all operand/pipeline registers.
REQ-026 rst SHALL take priority over start; rst during any busy state SHALL abort with no ready pulse.
REQ-027 First start SHALL be accepted on the first edge with rst=0.

Structure
REQ-028 Package float_pkg SHALL hold the FSM state enum, default EXP_W/MAN_W, and canonical NaN/infinity constant functions of EXP_W/MAN_W.
REQ-029 Leading-zero count SHALL be a separate parametrised combinational sub-module lzc (width MAN_W+4).
REQ-030 Defaults SHALL be a drop-in replacement for the existing fixed 1.5-minus block (op tied 0).

Verification
REQ-031 op=0, float_in=32'h3F800000 (1.0) -> float_out=32'h3F000000 (0.5), ready high exactly 5 edges after start.
REQ-032 op=0, float_in=32'h3FC00000 -> 32'h00000000; op=1, float_in=32'h40000000 (2.0) -> 32'h3F000000.
REQ-033 op=0, float_in=32'h7FC00001 -> 32'h7FC00000; float_in=32'h7F800000 -> 32'hFF800000.
REQ-034 op=0, float_in=32'h33800000 (2^-24) -> 32'h3FC00000 (tie rounds to even); float_in=32'h00000001 -> 32'h3FC00000.
REQ-035 rst asserted in NORM -> next edge ready=0, float_out=0, IDLE; start pulses while busy ignored; 10 back-to-back vectors restarting from DONE each match expected values.
